// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host loader: command opcodes, controller
// states, NPU region selects and well-known control word indices.
package npu_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_BLOCK = 2'd0,
        OP_TRIGGER     = 2'd1,
        OP_POLL        = 2'd2,
        OP_RSVD        = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_TRIG,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_RESP
    } state_e;

    // Region selects (npu_addra[14:12])
    localparam logic [2:0] SEL_WC1  = 3'd1;
    localparam logic [2:0] SEL_WC2  = 3'd2;
    localparam logic [2:0] SEL_FC1  = 3'd3;
    localparam logic [2:0] SEL_FC2  = 3'd4;
    localparam logic [2:0] SEL_CTRL = 3'd5;
    localparam logic [2:0] SEL_IMG  = 3'd6;

    // Control word indices inside SEL_CTRL
    localparam logic [11:0] IDX_START    = 12'd2;
    localparam logic [11:0] IDX_FC1_NEXT = 12'd3;

    // NPU port address: bit 15 is always clear
    function automatic logic [15:0] npu_addr(input logic [2:0] sel, input logic [11:0] idx);
        return {1'b0, sel, idx};
    endfunction

endpackage

// File: rtl/npu_host_loader.sv
// Host-side loader for the NPU memory port: block writes, trigger writes and
// status polling with a one-cycle response pulse.
// Optional feature macro: NPU_LOADER_POLL_EN (status read/poll loop). Without
// it a POLL answers immediately with rsp_data=0, rsp_timeout=1.
module npu_host_loader
    import npu_pkg::*;
#(
    parameter int unsigned POLL_MAX = 1024,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic [11:0] cmd_idx,
    input  logic [11:0] cmd_len,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    input  logic [31:0] wdata,
    output logic        npu_ena,
    output logic        npu_wea,
    output logic [15:0] npu_addra,
    output logic [31:0] npu_dina,
    input  logic [31:0] npu_douta,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        busy
);

    state_e      state;
    logic [2:0]  sel_q;
    logic [11:0] idx_q;
    logic [11:0] rem_q;
    op_e         op_in;

    assign op_in = op_e'(cmd_op);

`ifdef NPU_LOADER_POLL_EN
    localparam int unsigned PCW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    localparam int unsigned WCW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    logic [PCW-1:0] poll_cnt;
    logic [WCW-1:0] wait_cnt;
`else
    logic unused_nopoll;
    assign unused_nopoll = ^{npu_douta, 32'(POLL_MAX), 32'(READ_LAT)};
`endif

    // NPU port and handshakes decode from state; write beats pass straight through.
    // Everything is gated by rst so an abort cannot leak a final access.
    always_comb begin
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        busy        = 1'b0;
        rsp_valid   = 1'b0;
        npu_ena     = 1'b0;
        npu_wea     = 1'b0;
        npu_addra   = '0;
        npu_dina    = '0;
        if (!rst) begin
            cmd_ready = (state == ST_IDLE);
            busy      = (state != ST_IDLE);
            rsp_valid = (state == ST_RESP);
            npu_addra = npu_addr(sel_q, idx_q);
            case (state)
                ST_WRITE: begin
                    wdata_ready = 1'b1;
                    npu_ena     = wdata_valid;
                    npu_wea     = wdata_valid;
                    npu_dina    = wdata;
                end
                ST_TRIG: begin
                    npu_ena = 1'b1;
                    npu_wea = 1'b1;
                end
`ifdef NPU_LOADER_POLL_EN
                ST_POLL_RD: npu_ena = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Controller FSM: command capture, beat counting, poll loop and response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            idx_q       <= '0;
            rem_q       <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
`ifdef NPU_LOADER_POLL_EN
            poll_cnt    <= '0;
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        sel_q <= cmd_sel;
                        idx_q <= cmd_idx;
                        rem_q <= cmd_len;
`ifdef NPU_LOADER_POLL_EN
                        poll_cnt <= '0;
`endif
                        case (op_in)
                            OP_WRITE_BLOCK: if (cmd_len != '0) state <= ST_WRITE;
                            OP_TRIGGER:     state <= ST_TRIG;
`ifdef NPU_LOADER_POLL_EN
                            OP_POLL:        state <= ST_POLL_RD;
`else
                            OP_POLL: begin
                                state       <= ST_RESP;
                                rsp_data    <= '0;
                                rsp_timeout <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                ST_WRITE: begin
                    if (wdata_valid) begin
                        idx_q <= idx_q + 12'd1;
                        rem_q <= rem_q - 12'd1;
                        if (rem_q == 12'd1) state <= ST_IDLE;
                    end
                end
                ST_TRIG: state <= ST_IDLE;
`ifdef NPU_LOADER_POLL_EN
                ST_POLL_RD: begin
                    wait_cnt <= '0;
                    state    <= ST_POLL_WAIT;
                end
                ST_POLL_WAIT: begin
                    // rsp_data is only loaded on the way into RESP so it holds between responses
                    if (wait_cnt == WCW'(READ_LAT - 1)) begin
                        if (npu_douta[0]) begin
                            rsp_data    <= npu_douta;
                            rsp_timeout <= 1'b0;
                            state       <= ST_RESP;
                        end else if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                            rsp_data    <= npu_douta;
                            rsp_timeout <= 1'b1;
                            state       <= ST_RESP;
                        end else begin
                            poll_cnt <= poll_cnt + PCW'(1);
                            state    <= ST_POLL_RD;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
`endif
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npu_host_loader.sv
// Scoreboard bench for npu_host_loader: drivers push expected NPU accesses and
// responses into queues, a negedge monitor pops and compares them.
module tb_npu_host_loader;
    import npu_pkg::*;

    localparam int unsigned PMAX = 4;
    localparam int unsigned RLAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_sel;
    logic [11:0] cmd_idx;
    logic [11:0] cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        npu_ena;
    logic        npu_wea;
    logic [15:0] npu_addra;
    logic [31:0] npu_dina;
    logic [31:0] npu_douta;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;

    always #5 clk = ~clk;

    npu_host_loader #(.POLL_MAX(PMAX), .READ_LAT(RLAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sel(cmd_sel), .cmd_idx(cmd_idx), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .npu_ena(npu_ena), .npu_wea(npu_wea), .npu_addra(npu_addra),
        .npu_dina(npu_dina), .npu_douta(npu_douta),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .busy(busy)
    );

    typedef struct packed {
        logic        wea;
        logic [15:0] addr;
        logic [31:0] dina;
    } acc_t;

    typedef struct packed {
        logic [31:0] data;
        logic        tmo;
    } rsp_t;

    acc_t exp_acc[$];
    rsp_t exp_rsp[$];
    int   errors = 0;
    int   checks = 0;
    rsp_t last_rsp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // NPU status model: each read returns the next scripted word after RLAT cycles
    logic [31:0] poll_vals[$];
    int          read_no = 0;
    logic [31:0] rd_pipe [RLAT];
    initial for (int i = 0; i < RLAT; i++) rd_pipe[i] = '0;
    assign npu_douta = rd_pipe[RLAT-1];

    always @(posedge clk) begin
        logic [31:0] v;
        v    = $urandom;
        v[0] = 1'b0;
        if (npu_ena && !npu_wea && !rst) begin
            if (read_no < poll_vals.size()) v = poll_vals[read_no];
            read_no++;
        end
        rd_pipe[0] <= v;
        for (int i = 1; i < RLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Monitor: compare every NPU access and every response against the queues
    logic prev_rsp = 1'b0;
    always @(negedge clk) begin
        acc_t e;
        rsp_t r;
        if (npu_wea) check("wea_without_ena", 64'(npu_ena), 64'(1));
        if (npu_ena) begin
            check("addra_msb", 64'(npu_addra[15]), 64'(0));
            if (exp_acc.size() == 0) begin
                check("spurious_ena", 64'(npu_ena), 64'(0));
            end else begin
                e = exp_acc.pop_front();
                check("npu_wea", 64'(npu_wea), 64'(e.wea));
                check("npu_addra", 64'(npu_addra), 64'(e.addr));
                if (e.wea) check("npu_dina", 64'(npu_dina), 64'(e.dina));
            end
        end
        if (rsp_valid) begin
            check("rsp_pulse_width", 64'(prev_rsp), 64'(0));
            if (exp_rsp.size() == 0) begin
                check("spurious_rsp", 64'(rsp_valid), 64'(0));
            end else begin
                r = exp_rsp.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(r.data));
                check("rsp_timeout", 64'(rsp_timeout), 64'(r.tmo));
            end
        end
        prev_rsp = rsp_valid;
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({name, "_idle_timeout"}, 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] sel,
                         input logic [11:0] idx, input logic [11:0] len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_sel   = sel;
        cmd_idx   = idx;
        cmd_len   = len;
        @(negedge clk);
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("cmd_accept_timeout", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = $urandom;
    endtask

    // gap_mode: 0 none, 1 random, 2 single gap before beat 1; abort_at: beat index that gets rst
    task automatic do_write(input logic [2:0] sel, input logic [11:0] idx, input int len,
                            input int gap_mode, input int abort_at);
        logic [31:0] d[$];
        int gaps;
        int n;
        for (int k = 0; k < len; k++) d.push_back($urandom);
        for (int k = 0; k < len && k < abort_at; k++)
            exp_acc.push_back('{1'b1, {1'b0, sel, 12'((int'(idx) + k) % 4096)}, d[k]});
        issue(OP_WRITE_BLOCK, sel, idx, 12'(len));
        if (len == 0) begin
            @(negedge clk);
            check("len0_cmd_ready", 64'(cmd_ready), 64'(1));
            check("len0_busy", 64'(busy), 64'(0));
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < len; k++) begin
            gaps = (gap_mode == 1) ? int'($urandom_range(0, 2)) : (gap_mode == 2 && k == 1) ? 1 : 0;
            for (int g = 0; g < gaps; g++) begin
                wdata_valid = 1'b0;
                wdata       = $urandom;
                @(negedge clk);
                check("bubble_ena", 64'(npu_ena), 64'(0));
                check("bubble_wdata_ready", 64'(wdata_ready), 64'(1));
                @(posedge clk);
                #1;
            end
            wdata_valid = 1'b1;
            wdata       = d[k];
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst         = 1'b0;
                wdata_valid = 1'b0;
                read_no     = 0;
                @(negedge clk);
                check("abort_cmd_ready", 64'(cmd_ready), 64'(1));
                check("abort_busy", 64'(busy), 64'(0));
                check("abort_rsp_valid", 64'(rsp_valid), 64'(0));
                repeat (4) @(negedge clk);
                check("abort_no_ena", 64'(npu_ena), 64'(0));
                last_rsp = '0;
                @(posedge clk);
                #1;
                return;
            end
            n = 0;
            @(negedge clk);
            while (!wdata_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (n >= 100) check("wdata_ready_timeout", 64'(wdata_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        wdata_valid = 1'b0;
        wait_idle("write");
        check("write_done_wdata_ready", 64'(wdata_ready), 64'(0));
    endtask

    task automatic do_trigger(input logic [2:0] sel, input logic [11:0] idx);
        int n = 0;
        exp_acc.push_back('{1'b1, {1'b0, sel, idx}, 32'h0});
        issue(OP_TRIGGER, sel, idx, 12'($urandom));
        @(negedge clk);
        while (busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("trigger_busy_cycles", 64'(n), 64'(1));
        @(posedge clk);
        #1;
    endtask

    // ready_on: 1-based read number whose bit0 is first set
    task automatic do_poll(input logic [2:0] sel, input logic [11:0] idx, input int ready_on);
        rsp_t r;
        int   nreads;
        poll_vals.delete();
        for (int i = 1; i <= int'(PMAX); i++) begin
            logic [31:0] v;
            v    = $urandom;
            v[0] = (i >= ready_on);
            poll_vals.push_back(v);
        end
`ifdef NPU_LOADER_POLL_EN
        if (ready_on <= int'(PMAX)) begin
            nreads = ready_on;
            r      = '{poll_vals[ready_on-1], 1'b0};
        end else begin
            nreads = PMAX;
            r      = '{poll_vals[PMAX-1], 1'b1};
        end
`else
        nreads = 0;
        r      = '{32'h0, 1'b1};
`endif
        for (int i = 0; i < nreads; i++) exp_acc.push_back('{1'b0, {1'b0, sel, idx}, 32'h0});
        exp_rsp.push_back(r);
        last_rsp = r;
        read_no  = 0;
        issue(OP_POLL, sel, idx, 12'($urandom));
        wait_idle("poll");
        check("poll_reads", 64'(read_no), 64'(nreads));
        check("rsp_data_held", 64'(rsp_data), 64'(r.data));
        check("rsp_timeout_held", 64'(rsp_timeout), 64'(r.tmo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [11:0] ridx;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_sel     = '0;
        cmd_idx     = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_npu_ena", 64'(npu_ena), 64'(0));
        check("rst_wdata_ready", 64'(wdata_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_data", 64'(rsp_data), 64'(0));
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        @(posedge clk);
        #1;

        do_write(SEL_IMG, 12'd0, 60, 0, 1000);
        do_write(SEL_WC1, 12'd4094, 3, 2, 1000);
        do_write(SEL_FC1, 12'd7, 0, 0, 1000);
        do_trigger(SEL_CTRL, IDX_START);
        do_poll(SEL_CTRL, 12'd0, 3);
        do_poll(SEL_CTRL, 12'd0, 6);
        issue(OP_RSVD, SEL_FC2, 12'd9, 12'd5);
        @(negedge clk);
        check("rsvd_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rsvd_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        do_write(SEL_WC2, 12'd100, 10, 0, 4);

        for (int t = 0; t < 30; t++) begin
            ridx = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(4088, 4095)) : 12'($urandom);
            case ($urandom_range(0, 3))
                0: do_write(3'($urandom), ridx, int'($urandom_range(0, 8)), 1, 1000);
                1: do_trigger(3'($urandom), ridx);
                2: do_poll(3'($urandom), ridx, int'($urandom_range(1, 6)));
                default: begin
                    issue(OP_RSVD, 3'($urandom), ridx, 12'($urandom));
                    wait_idle("rsvd");
                end
            endcase
        end

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_rsp_data", 64'(rsp_data), 64'(last_rsp.data));
        check("exp_acc_empty", 64'(exp_acc.size()), 64'(0));
        check("exp_rsp_empty", 64'(exp_rsp.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
